// File: rtl/text_screen_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// text_screen_ctrl_pkg
// Shared definitions for the text-mode screen buffer controller:
//   - default geometry / width parameters
//   - ASCII control and fill constants
//   - sweep FSM state encoding
//   - phys_addr(): logical (row, col) to physical RAM address via the
//     circular top-row pointer
// ---------------------------------------------------------------------------
package text_screen_ctrl_pkg;

    localparam int DEF_COLS   = 70;
    localparam int DEF_ROWS   = 30;
    localparam int DEF_CHAR_W = 8;
    localparam int DEF_COL_W  = 7;
    localparam int DEF_ROW_W  = 5;

    localparam logic [7:0] CH_CR       = 8'h0D;
    localparam logic [7:0] CH_BS       = 8'h08;
    localparam logic [7:0] CH_FF       = 8'h0C;
    localparam logic [7:0] CH_BLANK    = 8'h20;
    localparam logic [7:0] CH_PRINT_LO = 8'h20;
    localparam logic [7:0] CH_PRINT_HI = 8'h7E;

    typedef enum logic [1:0] {
        ST_CLEAR  = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SCROLL = 2'd2
    } state_e;

    // Both row and top are below rows, so one conditional subtract replaces
    // a general modulo.
    function automatic int unsigned phys_addr(input int unsigned row,
                                              input int unsigned col,
                                              input int unsigned top,
                                              input int unsigned rows,
                                              input int unsigned cols);
        int unsigned phys_row;
        phys_row = row + top;
        if (phys_row >= rows) phys_row = phys_row - rows;
        return phys_row * cols + col;
    endfunction

endpackage

// File: rtl/text_screen_ctrl_if.sv
// ---------------------------------------------------------------------------
// text_screen_ctrl_if
// Bundles the keyboard input handshake, the renderer read port and the
// cursor/status outputs of text_screen_ctrl.
//   master : keyboard path + renderer side (drives in_char/in_valid/rd_*)
//   slave  : the controller (drives in_ready, rd_data, rd_cursor, cursor_*,
//            busy)
// ---------------------------------------------------------------------------
interface text_screen_ctrl_if
    import text_screen_ctrl_pkg::*;
#(
    parameter int CHAR_W = DEF_CHAR_W,
    parameter int COL_W  = DEF_COL_W,
    parameter int ROW_W  = DEF_ROW_W
);
    logic [CHAR_W-1:0] in_char;
    logic              in_valid;
    logic              in_ready;
    logic [COL_W-1:0]  rd_col;
    logic [ROW_W-1:0]  rd_row;
    logic [CHAR_W-1:0] rd_data;
    logic              rd_cursor;
    logic [COL_W-1:0]  cursor_col;
    logic [ROW_W-1:0]  cursor_row;
    logic              busy;

    modport master (
        output in_char, in_valid, rd_col, rd_row,
        input  in_ready, rd_data, rd_cursor, cursor_col, cursor_row, busy
    );

    modport slave (
        input  in_char, in_valid, rd_col, rd_row,
        output in_ready, rd_data, rd_cursor, cursor_col, cursor_row, busy
    );

endinterface

// File: rtl/text_screen_ram.sv
// ---------------------------------------------------------------------------
// text_screen_ram
// Character RAM: one synchronous write port, one synchronous read port with
// a registered output. A read and write to the same address in one cycle
// returns the old contents.
// Ports:
//   clk      : clock
//   i_we     : write enable
//   i_waddr  : write address
//   i_wdata  : write data
//   i_raddr  : read address
//   o_rdata  : read data, valid one cycle after i_raddr
// ---------------------------------------------------------------------------
module text_screen_ram #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2100,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    // NOTE: the array has no reset; the controller's clear sweep initialises
    // it, and leaving it unreset lets it map onto block RAM.
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/text_screen_ctrl.sv
// ---------------------------------------------------------------------------
// text_screen_ctrl
// Text-mode screen buffer between the keyboard ASCII stream and the VGA
// character renderer. Handles cursor movement, line wrap, backspace,
// hardware scrolling through a circular top-row pointer, and full clear.
// Ports:
//   clk : clock
//   rst : synchronous, active-high reset (restarts the clear sweep)
//   bus : text_screen_ctrl_if.slave
//         in_char/in_valid/in_ready : character input handshake
//         rd_row/rd_col -> rd_data/rd_cursor : 1-cycle logical read port
//         cursor_row/cursor_col, busy : status
// ---------------------------------------------------------------------------
module text_screen_ctrl
    import text_screen_ctrl_pkg::*;
#(
    parameter int                 COLS   = DEF_COLS,
    parameter int                 ROWS   = DEF_ROWS,
    parameter int                 CHAR_W = DEF_CHAR_W,
    parameter int                 COL_W  = DEF_COL_W,
    parameter int                 ROW_W  = DEF_ROW_W,
    parameter logic [CHAR_W-1:0]  BLANK  = CHAR_W'(CH_BLANK)
) (
    input logic               clk,
    input logic               rst,
    text_screen_ctrl_if.slave bus
);

    localparam int CELLS  = ROWS * COLS;
    localparam int ADDR_W = $clog2(CELLS);

    localparam logic [1:0] S_CLEAR  = ST_CLEAR;
    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SCROLL = ST_SCROLL;

    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_sweep;
    logic [ADDR_W-1:0] r_sweep_end;
    logic [ROW_W-1:0]  r_top;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic              r_rd_valid;
    logic              r_rd_cursor;

    logic              w_accept;
    logic              w_printable;
    logic              w_is_cr;
    logic              w_is_bs;
    logic              w_is_ff;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [CHAR_W-1:0] w_wdata;
    logic [ADDR_W-1:0] w_scroll_base;
    logic              w_rd_in_range;
    logic [ADDR_W-1:0] w_raddr;
    logic [CHAR_W-1:0] w_rdata;

    // Input decode and write-port mux.
    // NOTE: combinational blocks use blocking assignments and give every
    // output a default first, so no latch is inferred on untaken paths.
    always_comb begin
        w_accept    = (r_state == S_IDLE) && bus.in_valid;
        w_printable = (bus.in_char >= CHAR_W'(CH_PRINT_LO)) &&
                      (bus.in_char <= CHAR_W'(CH_PRINT_HI));
        w_is_cr     = (bus.in_char == CHAR_W'(CH_CR));
        w_is_bs     = (bus.in_char == CHAR_W'(CH_BS));
        w_is_ff     = (bus.in_char == CHAR_W'(CH_FF));

        // After top advances, the new bottom logical row is the physical row
        // that used to be on top.
        w_scroll_base = ADDR_W'(phys_addr(0, 0, 32'(r_top), ROWS, COLS));

        w_we    = 1'b0;
        w_waddr = r_sweep;
        w_wdata = BLANK;
        if (r_state != S_IDLE) begin
            w_we = 1'b1;
        end else if (w_accept) begin
            if (w_printable) begin
                w_we    = 1'b1;
                w_waddr = ADDR_W'(phys_addr(32'(r_row), 32'(r_col), 32'(r_top), ROWS, COLS));
                w_wdata = bus.in_char;
            end else if (w_is_bs && r_col != '0) begin
                w_we    = 1'b1;
                w_waddr = ADDR_W'(phys_addr(32'(r_row), 32'(r_col) - 1, 32'(r_top), ROWS, COLS));
            end else if (w_is_bs && r_row != '0) begin
                w_we    = 1'b1;
                w_waddr = ADDR_W'(phys_addr(32'(r_row) - 1, 32'(LAST_COL), 32'(r_top), ROWS, COLS));
            end
        end

        w_rd_in_range = (32'(bus.rd_col) < 32'(COLS)) && (32'(bus.rd_row) < 32'(ROWS));
        w_raddr       = w_rd_in_range ?
                        ADDR_W'(phys_addr(32'(bus.rd_row), 32'(bus.rd_col), 32'(r_top), ROWS, COLS)) :
                        '0;
    end

    // Sweep FSM, cursor and top-row pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_CLEAR;
            r_sweep     <= '0;
            r_sweep_end <= LAST_CELL;
            r_top       <= '0;
            r_row       <= '0;
            r_col       <= '0;
        end else begin
            case (r_state)
                S_CLEAR, S_SCROLL: begin
                    if (r_sweep == r_sweep_end) r_state <= S_IDLE;
                    else                        r_sweep <= r_sweep + 1'b1;
                end
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_is_ff) begin
                            r_state     <= S_CLEAR;
                            r_sweep     <= '0;
                            r_sweep_end <= LAST_CELL;
                            r_top       <= '0;
                            r_row       <= '0;
                            r_col       <= '0;
                        end else if (w_printable && r_col != LAST_COL) begin
                            r_col <= r_col + 1'b1;
                        end else if (w_printable || w_is_cr) begin
                            // Newline: the character (if any) is written with
                            // the old top this cycle, then top advances.
                            r_col <= '0;
                            if (r_row != LAST_ROW) begin
                                r_row <= r_row + 1'b1;
                            end else begin
                                r_top       <= (r_top == LAST_ROW) ? '0 : r_top + 1'b1;
                                r_state     <= S_SCROLL;
                                r_sweep     <= w_scroll_base;
                                r_sweep_end <= w_scroll_base + ADDR_W'(COLS - 1);
                            end
                        end else if (w_is_bs) begin
                            if (r_col != '0) begin
                                r_col <= r_col - 1'b1;
                            end else if (r_row != '0) begin
                                r_row <= r_row - 1'b1;
                                r_col <= LAST_COL;
                            end
                        end
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    // Read-side qualifiers travel alongside the RAM's registered output.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid  <= 1'b0;
            r_rd_cursor <= 1'b0;
        end else begin
            r_rd_valid  <= w_rd_in_range;
            r_rd_cursor <= w_rd_in_range && (bus.rd_row == r_row) && (bus.rd_col == r_col);
        end
    end

    text_screen_ram #(
        .DATA_W (CHAR_W),
        .DEPTH  (CELLS),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (w_raddr),
        .o_rdata (w_rdata)
    );

    assign bus.in_ready   = (r_state == S_IDLE);
    assign bus.busy       = (r_state != S_IDLE);
    assign bus.rd_data    = r_rd_valid ? w_rdata : BLANK;
    assign bus.rd_cursor  = r_rd_cursor;
    assign bus.cursor_col = r_col;
    assign bus.cursor_row = r_row;

endmodule

// File: tb/tb_text_screen_ctrl.sv
// ---------------------------------------------------------------------------
// tb_text_screen_ctrl
// Self-checking bench for text_screen_ctrl. The reference model keeps the
// visible screen as a logical 2-D character array: scrolling shifts rows up
// and blanks the last one, so it never needs a top-row pointer.
// ---------------------------------------------------------------------------
module tb_text_screen_ctrl;

    localparam int COLS   = 70;
    localparam int ROWS   = 30;
    localparam int CHAR_W = 8;
    localparam int COL_W  = 7;
    localparam int ROW_W  = 5;
    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;
    localparam logic [7:0] FF = 8'h0C;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] scr [ROWS][COLS];
    int         mrow;
    int         mcol;

    text_screen_ctrl_if #(.CHAR_W(CHAR_W), .COL_W(COL_W), .ROW_W(ROW_W)) bus ();

    text_screen_ctrl #(
        .COLS(COLS), .ROWS(ROWS), .CHAR_W(CHAR_W),
        .COL_W(COL_W), .ROW_W(ROW_W), .BLANK(8'h20)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void model_blank_all();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = SP;
        mrow = 0;
        mcol = 0;
    endfunction

    function automatic bit model_newline();
        if (mrow < ROWS - 1) begin
            mrow++;
            return 1'b0;
        end
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = scr[r+1][c];
        for (int c = 0; c < COLS; c++) scr[ROWS-1][c] = SP;
        return 1'b1;
    endfunction

    task automatic model_char(input logic [7:0] ch, output bit scrolled, output bit cleared);
        scrolled = 1'b0;
        cleared  = 1'b0;
        if (ch == FF) begin
            model_blank_all();
            cleared = 1'b1;
        end else if (ch >= 8'h20 && ch <= 8'h7E) begin
            scr[mrow][mcol] = ch;
            if (mcol == COLS - 1) begin
                mcol = 0;
                scrolled = model_newline();
            end else begin
                mcol++;
            end
        end else if (ch == CR) begin
            mcol = 0;
            scrolled = model_newline();
        end else if (ch == BS) begin
            if (mcol > 0) begin
                mcol--;
                scr[mrow][mcol] = SP;
            end else if (mrow > 0) begin
                mrow--;
                mcol = COLS - 1;
                scr[mrow][mcol] = SP;
            end
        end
    endtask

    function automatic logic [7:0] rand_char();
        int unsigned k;
        k = $urandom_range(0, 99);
        if (k < 68) return 8'($urandom_range(32, 126));
        if (k < 80) return CR;
        if (k < 92) return BS;
        if (k < 95) return 8'h7F;
        if (k < 97) return 8'($urandom_range(0, 7));
        return 8'($urandom_range(128, 255));
    endfunction

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; holds in_valid until the DUT takes the character,
    // then checks cursor, handshake and sweep length against the model.
    task automatic send(input logic [7:0] ch);
        int n;
        bit acc, sc, cl;
        bus.in_char  = ch;
        bus.in_valid = 1'b1;
        n = 0;
        do begin
            acc = bus.in_ready;
            @(negedge clk);
            n++;
        end while (!acc && n < 5000);
        bus.in_valid = 1'b0;
        bus.in_char  = 8'($urandom);
        check("accept", {31'd0, acc}, 32'd1);
        model_char(ch, sc, cl);
        check("cursor_col", 32'(bus.cursor_col), 32'(mcol));
        check("cursor_row", 32'(bus.cursor_row), 32'(mrow));
        check("busy_after_char", {31'd0, bus.busy}, {31'd0, sc || cl});
        if (sc || cl) begin
            n = 0;
            while (bus.in_ready !== 1'b1 && n < 5000) begin
                @(negedge clk);
                n++;
            end
            check(sc ? "scroll_len" : "clear_len", 32'(n), sc ? 32'(COLS) : 32'(ROWS * COLS));
        end
    endtask

    task automatic rd(input int r, input int c);
        bus.rd_row = ROW_W'(r);
        bus.rd_col = COL_W'(c);
        @(negedge clk);
    endtask

    task automatic check_screen(input string tag);
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) begin
                rd(r, c);
                check($sformatf("%s data r%0d c%0d", tag, r, c), 32'(bus.rd_data), 32'(scr[r][c]));
                check($sformatf("%s rd_cursor r%0d c%0d", tag, r, c), {31'd0, bus.rd_cursor},
                      {31'd0, (r == mrow && c == mcol)});
            end
    endtask

    // Reset with a character pending on the input; it must be dropped and
    // the full clear must run from cell 0.
    task automatic do_reset(input string tag);
        int n;
        rst          = 1'b1;
        bus.in_char  = 8'h58;
        bus.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        check({tag, " rst_in_ready"}, {31'd0, bus.in_ready}, 32'd0);
        check({tag, " rst_busy"}, {31'd0, bus.busy}, 32'd1);
        check({tag, " rst_rd_data"}, 32'(bus.rd_data), 32'(SP));
        check({tag, " rst_rd_cursor"}, {31'd0, bus.rd_cursor}, 32'd0);
        rst = 1'b0;
        n = 0;
        while (bus.busy === 1'b1 && n < 5000) begin
            check({tag, " ready_low_in_clear"}, {31'd0, bus.in_ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        bus.in_valid = 1'b0;
        check({tag, " clear_len"}, 32'(n), 32'(ROWS * COLS));
        check({tag, " ready_after_clear"}, {31'd0, bus.in_ready}, 32'd1);
        model_blank_all();
        check({tag, " cursor_col"}, 32'(bus.cursor_col), 32'd0);
        check({tag, " cursor_row"}, 32'(bus.cursor_row), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int guard;
        bus.in_valid = 1'b0;
        bus.in_char  = '0;
        bus.rd_row   = '0;
        bus.rd_col   = '0;
        model_blank_all();

        // Power-on reset and clear sweep.
        do_reset("por");
        check_screen("por");

        // "Hi" and read-port latency / cursor flag.
        send(8'h48);
        send(8'h69);
        rd(0, 0);
        check("hi_c0", 32'(bus.rd_data), 32'h48);
        rd(0, 1);
        check("hi_c1", 32'(bus.rd_data), 32'h69);
        check("hi_c1_cursor", {31'd0, bus.rd_cursor}, 32'd0);
        bus.rd_row = 0;
        bus.rd_col = 2;
        #1;
        check("rd_registered", 32'(bus.rd_data), 32'h69);
        @(negedge clk);
        check("hi_c2", 32'(bus.rd_data), 32'(SP));
        check("hi_c2_cursor", {31'd0, bus.rd_cursor}, 32'd1);
        rd(0, 3);
        check("hi_c3_cursor", {31'd0, bus.rd_cursor}, 32'd0);

        // Form feed, full line of 'A' wraps, backspace across the wrap.
        send(FF);
        repeat (COLS) send(8'h41);
        send(BS);
        check_screen("row_a_bs");

        // Fill to the last row, then scroll once.
        send(FF);
        repeat (ROWS - 1) send(CR);
        send(8'h5A);
        send(CR);
        check_screen("scroll1");

        // Out-of-range reads; (27,70) would alias onto the 'Z' cell if the
        // range check were missing.
        rd(27, COLS);
        check("oor_col_data", 32'(bus.rd_data), 32'(SP));
        check("oor_col_cursor", {31'd0, bus.rd_cursor}, 32'd0);
        rd(ROWS, 0);
        check("oor_row_data", 32'(bus.rd_data), 32'(SP));
        rd(31, 127);
        check("oor_max_data", 32'(bus.rd_data), 32'(SP));
        check("oor_max_cursor", {31'd0, bus.rd_cursor}, 32'd0);

        // 31 more scrolls so the top pointer wraps past zero.
        for (int i = 0; i < 31; i++) begin
            send(8'($urandom_range(33, 126)));
            send(CR);
        end
        check_screen("scroll31");

        // Random character stream against the model.
        for (int i = 0; i < 400; i++) send(rand_char());
        check_screen("random");

        // Form feed from wherever the cursor ended up.
        send(FF);
        check_screen("ff");

        // Put content on screen, move to the last row, start a scroll and
        // reset in the middle of it.
        for (int i = 0; i < 40; i++) send(8'($urandom_range(33, 126)));
        guard = 0;
        while (mrow != ROWS - 1 && guard < ROWS) begin
            send(CR);
            guard++;
        end
        check("mid_on_last_row", 32'(bus.cursor_row), 32'(ROWS - 1));
        check("mid_ready", {31'd0, bus.in_ready}, 32'd1);
        bus.in_char  = CR;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (20) @(negedge clk);
        check("mid_scroll_busy", {31'd0, bus.busy}, 32'd1);
        do_reset("mid_rst");
        check_screen("after_mid_rst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
